// File: rtl/div_result_bcd.sv
// ---------------------------------------------------------------------------
// div_result_bcd
//   Takes the Divisor's quotient (cociente) and remainder (residuo) and turns
//   both into packed BCD for the 7-segment display mux. The conversion is a
//   sequential double-dabble (shift-add-3): one binary bit per clock, with
//   both operands handled in lockstep. A conversion takes WIDTH clocks from
//   the accepting edge. q_bcd/r_bcd hold their value until the next
//   conversion completes.
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous, active-high reset (highest priority)
//   start     request pulse; operands are sampled on the accepting edge
//   cociente  [WIDTH-1:0]     quotient to convert
//   residuo   [WIDTH-1:0]     remainder to convert
//   busy      high while a conversion is in flight
//   done      one-cycle pulse; q_bcd/r_bcd are valid from this cycle
//   q_bcd     [4*DIGITS-1:0]  packed BCD of cociente, digit 0 in [3:0]
//   r_bcd     [4*DIGITS-1:0]  packed BCD of residuo
//
// Optional build macro DIV_ZERO_FLAG_EN
//   Adds input div_zero and output err. When a request arrives with
//   div_zero=1, the shifting is skipped. One edge later both results read
//   all-0xE nibbles and err=1. err holds until the next done or rst.
//
// Parameters must satisfy 10**DIGITS > 2**WIDTH-1. This keeps the top nibble
// from ever exceeding 9.
// ---------------------------------------------------------------------------

// Per-digit double-dabble correction: add 3 to a nibble that is 5 or more,
// so the following left shift carries into the next decimal digit.
module div_result_bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module div_result_bcd #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      cociente,
    input  logic [WIDTH-1:0]      residuo,
`ifdef DIV_ZERO_FLAG_EN
    input  logic                  div_zero,
    output logic                  err,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   q_bcd,
    output logic [4*DIGITS-1:0]   r_bcd
);

    localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CAT = 4*DIGITS + WIDTH;
    localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                     state, state_n;
    logic [WIDTH-1:0]           qbin, rbin, qbin_n, rbin_n;
    logic [DIGITS-1:0][3:0]     qacc, racc, qacc_n, racc_n;
    logic [DIGITS-1:0][3:0]     qcor, rcor;
    logic [CW-1:0]              cnt, cnt_n;
    logic                       busy_n, done_n;
    logic [4*DIGITS-1:0]        q_bcd_n, r_bcd_n;
    logic [CAT-1:0]             qcat, rcat;
`ifdef DIV_ZERO_FLAG_EN
    logic                       zflag, zflag_n, err_n;
`endif

    // Correct every nibble of both accumulators before the shift.
    // The corrections are independent per nibble, with no carry between them.
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        div_result_bcd_add3 u_qadd (.din(qacc[g]), .dout(qcor[g]));
        div_result_bcd_add3 u_radd (.din(racc[g]), .dout(rcor[g]));
    end

    // The shift of {accumulator, binary}: the binary MSB enters BCD digit 0.
    assign qcat = {qcor, qbin} << 1;
    assign rcat = {rcor, rbin} << 1;

    always_comb begin
        state_n = state;
        qbin_n  = qbin;
        rbin_n  = rbin;
        qacc_n  = qacc;
        racc_n  = racc;
        cnt_n   = cnt;
        busy_n  = busy;
        done_n  = 1'b0;
        q_bcd_n = q_bcd;
        r_bcd_n = r_bcd;
`ifdef DIV_ZERO_FLAG_EN
        zflag_n = zflag;
        err_n   = err;
`endif
        case (state)
            IDLE: begin
                // This state also covers the done cycle, so a start issued
                // in the done cycle is taken without a gap.
                if (start) begin
                    qbin_n  = cociente;
                    rbin_n  = residuo;
                    qacc_n  = '0;
                    racc_n  = '0;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    state_n = SHIFT;
`ifdef DIV_ZERO_FLAG_EN
                    zflag_n = div_zero;
`endif
                end
            end
            SHIFT: begin
                // A start seen in this state is ignored on purpose: there is
                // no queueing, and the operands already captured are kept.
`ifdef DIV_ZERO_FLAG_EN
                if (zflag) begin
                    q_bcd_n = {DIGITS{4'hE}};
                    r_bcd_n = {DIGITS{4'hE}};
                    err_n   = 1'b1;
                    zflag_n = 1'b0;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else
`endif
                begin
                    qacc_n = qcat[CAT-1:WIDTH];
                    racc_n = rcat[CAT-1:WIDTH];
                    qbin_n = qcat[WIDTH-1:0];
                    rbin_n = rcat[WIDTH-1:0];
                    cnt_n  = cnt + 1'b1;
                    if (cnt == LAST) begin
                        // The outputs update in one step at the final edge.
                        q_bcd_n = qcat[CAT-1:WIDTH];
                        r_bcd_n = rcat[CAT-1:WIDTH];
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = IDLE;
`ifdef DIV_ZERO_FLAG_EN
                        err_n   = 1'b0;
`endif
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            qbin  <= '0;
            rbin  <= '0;
            qacc  <= '0;
            racc  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            q_bcd <= '0;
            r_bcd <= '0;
`ifdef DIV_ZERO_FLAG_EN
            zflag <= 1'b0;
            err   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            qbin  <= qbin_n;
            rbin  <= rbin_n;
            qacc  <= qacc_n;
            racc  <= racc_n;
            cnt   <= cnt_n;
            busy  <= busy_n;
            done  <= done_n;
            q_bcd <= q_bcd_n;
            r_bcd <= r_bcd_n;
`ifdef DIV_ZERO_FLAG_EN
            zflag <= zflag_n;
            err   <= err_n;
`endif
        end
    end

endmodule
